sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller sitting around the analog comparator macro in the tile: drives the trial code to the reference DAC (on uo_out) and consumes the comparator's asynchronous decision output (on ui_in). Converts one analog sample per start request into a WIDTH-bit code using binary search, MSB first. Owns all sequencing: track/hold, DAC settling, comparator-output synchronization, bit decisions and result handoff.

---
 rtl/sar_adc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold, DAC trial codes, synchronized comparator decisions, result handoff.
// Latency: SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+SYNC_STAGES) cycles from start acceptance to result/done.
// Backpressure: none; start is only sampled in IDLE, requests while busy or in DONE are dropped (no queuing).
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // One bit trial covers DAC settling plus the synchronizer delay so the
    // decision always reflects the comparator response to the current code.
    localparam int TRIAL_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
    localparam int PHASE_MAX    = (TRIAL_CYCLES > SAMPLE_CYCLES) ? TRIAL_CYCLES : SAMPLE_CYCLES;
    localparam int PW           = $clog2(PHASE_MAX + 1);
    localparam int BW           = $clog2(WIDTH);

    localparam logic [PW-1:0]    SAMPLE_LAST = PW'(SAMPLE_CYCLES - 1);
    localparam logic [PW-1:0]    TRIAL_LAST  = PW'(TRIAL_CYCLES - 1);
    localparam logic [BW-1:0]    MSB_IDX     = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_BIT,
        ST_DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PW-1:0]          phase_q;
    logic [PW-1:0]          phase_d;
    logic [BW-1:0]          bit_q;
    logic [BW-1:0]          bit_d;
    logic                   sample_d;
    logic [WIDTH-1:0]       dac_d;
    logic                   busy_d;
    logic                   done_d;
    logic [WIDTH-1:0]       result_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_sync;
    logic [WIDTH-1:0]       bit_mask;
    logic [WIDTH-1:0]       kept_code;

    assign cmp_sync  = sync_q[SYNC_STAGES-1];
    // Bit under trial; shifting it right gives the next trial bit.
    assign bit_mask  = WIDTH'(1) << bit_q;
    // Comparator low means the trial overshot the input: drop the bit.
    assign kept_code = cmp_sync ? dac_code : (dac_code & ~bit_mask);

    // Comparator synchronizer, free-running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            bit_q    <= '0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            sample   <= sample_d;
            dac_code <= dac_d;
            busy     <= busy_d;
            done     <= done_d;
            result   <= result_d;
        end
    end

    // Next-state and next-output logic for the conversion sequence.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sample_d = sample;
        dac_d    = dac_code;
        busy_d   = busy;
        done_d   = 1'b0;
        result_d = result;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    dac_d    = '0;
                    phase_d  = '0;
                end
            end

            ST_SAMPLE: begin
                if (phase_q == SAMPLE_LAST) begin
                    state_d  = ST_BIT;
                    sample_d = 1'b0;
                    bit_d    = MSB_IDX;
                    dac_d    = MSB_CODE;
                    phase_d  = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            ST_BIT: begin
                if (phase_q == TRIAL_LAST) begin
                    phase_d = '0;
                    if (bit_q != '0) begin
                        bit_d = bit_q - 1'b1;
                        dac_d = kept_code | (bit_mask >> 1);
                    end else begin
                        state_d  = ST_DONE;
                        dac_d    = kept_code;
                        result_d = kept_code;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
module tb_sar_adc_ctrl;

    // Instance 0: default parameters. Instance 1: reduced WIDTH=4 build.
    localparam int W0 = 8, S0 = 2, T0 = 4 + 2;
    localparam int W1 = 4, S1 = 1, T1 = 1 + 2;

    typedef struct packed {
        int         e0;
        logic [7:0] vin;
    } conv_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] vin0;
    logic [3:0] vin1;
    logic       cmp0, cmp1;
    logic       sample0, busy0, done0;
    logic       sample1, busy1, done1;
    logic [7:0] dac0, res0;
    logic [3:0] dac1, res1;

    logic       sample_x [2];
    logic       busy_x   [2];
    logic       done_x   [2];
    logic [7:0] dac_x    [2];
    logic [7:0] res_x    [2];

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    conv_t q0 [$];
    conv_t q1 [$];
    int    rd_ptr [2];
    logic [7:0] last_res [2];
    int    free_edge [2];
    bit    end_req = 0;
    bit    end_seen = 0;

    // Ideal comparator: 1 when the analog input is at or above the DAC level.
    assign cmp0 = (vin0 >= dac0);
    assign cmp1 = (vin1 >= dac1);

    assign sample_x[0] = sample0;
    assign busy_x[0]   = busy0;
    assign done_x[0]   = done0;
    assign dac_x[0]    = dac0;
    assign res_x[0]    = res0;
    assign sample_x[1] = sample1;
    assign busy_x[1]   = busy1;
    assign done_x[1]   = done1;
    assign dac_x[1]    = {4'h0, dac1};
    assign res_x[1]    = {4'h0, res1};

    sar_adc_ctrl dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .cmp_in   (cmp0),
        .sample   (sample0),
        .dac_code (dac0),
        .busy     (busy0),
        .done     (done0),
        .result   (res0)
    );

    sar_adc_ctrl #(
        .WIDTH         (4),
        .SAMPLE_CYCLES (1),
        .SETTLE_CYCLES (1),
        .SYNC_STAGES   (2)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .cmp_in   (cmp1),
        .sample   (sample1),
        .dac_code (dac1),
        .busy     (busy1),
        .done     (done1),
        .result   (res1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wd(input int d);
        return (d == 0) ? W0 : W1;
    endfunction
    function automatic int sc(input int d);
        return (d == 0) ? S0 : S1;
    endfunction
    function automatic int tc(input int d);
        return (d == 0) ? T0 : T1;
    endfunction

    // Binary search trial j: the top j bits already resolved equal the
    // input's top j bits, plus the next bit set for trial.
    function automatic logic [7:0] trial(input int w, input logic [7:0] vin, input int j);
        logic [7:0] top;
        logic [7:0] one;
        int sh;
        sh  = w - j;
        top = (vin >> sh) << sh;
        one = 8'd1;
        return top | (one << (w - 1 - j));
    endfunction

    // Compare one instance's outputs against the model for the current cycle.
    task automatic check_dut(input int d, input bit have, input conv_t f, output bit adv);
        int n, len;
        bit e_s, e_b, e_d, chk_dac;
        logic [7:0] e_dac, e_res;
        n = cyc;
        len = sc(d) + wd(d) * tc(d);
        adv = 0;
        chk_dac = 1;
        e_s = 0; e_b = 0; e_d = 0; e_dac = '0;
        e_res = last_res[d];
        if (!rst_n) begin
            e_res = '0;
            last_res[d] = '0;
        end else if (have && n >= f.e0 && n < f.e0 + sc(d)) begin
            e_s = 1; e_b = 1;
        end else if (have && n >= f.e0 + sc(d) && n < f.e0 + len) begin
            e_b = 1;
            e_dac = trial(wd(d), f.vin, (n - f.e0 - sc(d)) / tc(d));
        end else if (have && n == f.e0 + len) begin
            e_d = 1;
            e_dac = f.vin;
            e_res = f.vin;
            adv = 1;
        end else begin
            chk_dac = 0;
        end
        vectors++;
        if (sample_x[d] !== e_s || busy_x[d] !== e_b || done_x[d] !== e_d ||
            res_x[d] !== e_res || (chk_dac && dac_x[d] !== e_dac)) begin
            miscompares++;
            $display("FAIL dut%0d cyc %0d sample/busy/done/dac/result: got %0b/%0b/%0b/%02h/%02h required %0b/%0b/%0b/%s/%02h",
                     d, n, sample_x[d], busy_x[d], done_x[d], dac_x[d], res_x[d],
                     e_s, e_b, e_d, chk_dac ? $sformatf("%02h", e_dac) : "xx", e_res);
        end
        if (adv) last_res[d] = f.vin;
    endtask

    // Monitor: consumes expected conversions as the DUTs walk through them.
    always @(negedge clk) begin
        bit have, adv;
        conv_t f;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) rd_ptr[d] = (d == 0) ? q0.size() : q1.size();
            have = 0;
            f = '0;
            if (d == 0 && rd_ptr[0] < q0.size()) begin
                have = 1;
                f = q0[rd_ptr[0]];
            end
            if (d == 1 && rd_ptr[1] < q1.size()) begin
                have = 1;
                f = q1[rd_ptr[1]];
            end
            check_dut(d, have, f, adv);
            if (adv) rd_ptr[d]++;
        end
        if (end_req && !end_seen) begin
            end_seen = 1;
            vectors++;
            if (rd_ptr[0] != q0.size() || rd_ptr[1] != q1.size()) begin
                miscompares++;
                $display("FAIL drain: outstanding conversions %0d/%0d, required 0/0",
                         q0.size() - rd_ptr[0], q1.size() - rd_ptr[1]);
            end
        end
    end

    task automatic wait_slot();
        @(posedge clk);
        #1;
    endtask

    // Drive start for the coming edge and predict whether it is accepted.
    task automatic drive(input logic s0, input logic s1);
        conv_t c;
        start0 = s0;
        start1 = s1;
        if (s0 && rst_n && cyc + 1 >= free_edge[0]) begin
            c.e0 = cyc + 1;
            c.vin = vin0;
            q0.push_back(c);
            free_edge[0] = cyc + 1 + S0 + W0 * T0 + 2;
        end
        if (s1 && rst_n && cyc + 1 >= free_edge[1]) begin
            c.e0 = cyc + 1;
            c.vin = {4'h0, vin1};
            q1.push_back(c);
            free_edge[1] = cyc + 1 + S1 + W1 * T1 + 2;
        end
    endtask

    task automatic single_conv(input logic [7:0] v);
        vin0 = v;
        wait_slot();
        drive(1, 0);
        repeat (55) begin
            wait_slot();
            drive(0, 0);
        end
    endtask

    initial begin
        int e;
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        vin0 = '0;
        vin1 = '0;
        free_edge[0] = 0;
        free_edge[1] = 0;
        repeat (3) wait_slot();
        rst_n = 1'b1;
        repeat (2) begin
            wait_slot();
            drive(0, 0);
        end

        // Nominal conversion with extra start pulses mid-conversion.
        vin0 = 8'hA5;
        wait_slot();
        drive(1, 0);
        e = cyc + 1;
        repeat (58) begin
            wait_slot();
            drive((cyc + 1 == e + 10) || (cyc + 1 == e + 30), 0);
        end

        // Code-range extremes.
        single_conv(8'h00);
        single_conv(8'hFF);

        // start held high: back-to-back conversions.
        vin0 = 8'h3C;
        wait_slot();
        drive(1, 0);
        e = cyc + 1;
        repeat (103) begin
            wait_slot();
            if (cyc == e + 50) vin0 = 8'h91;
            drive(1, 0);
        end
        wait_slot();
        drive(0, 0);
        repeat (55) begin
            wait_slot();
            drive(0, 0);
        end

        // Reset in the middle of a conversion.
        vin0 = 8'h77;
        wait_slot();
        drive(1, 0);
        e = cyc + 1;
        while (cyc < e + 24) begin
            wait_slot();
            drive(0, 0);
        end
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        free_edge[0] = 0;
        free_edge[1] = 0;
        repeat (3) wait_slot();
        rst_n = 1'b1;
        wait_slot();
        drive(0, 0);
        single_conv(8'h5A);

        // Reduced-width instance.
        vin1 = 4'h9;
        wait_slot();
        drive(0, 1);
        repeat (18) begin
            wait_slot();
            drive(0, 0);
        end

        // Randomized traffic on both instances; the input only moves while
        // no bit decision can be pending.
        repeat (1500) begin
            wait_slot();
            if (cyc >= free_edge[0] - 2 && $urandom_range(0, 3) == 0) vin0 = 8'($urandom_range(0, 255));
            if (cyc >= free_edge[1] - 2 && $urandom_range(0, 3) == 0) vin1 = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end
        repeat (60) begin
            wait_slot();
            drive(0, 0);
        end

        end_req = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
